// File: rtl/regfile_mp_pkg.sv
// Shared defaults and helpers for the multi-port register file and its write-merge slice.
package regfile_mp_pkg;

    localparam int unsigned W_DEF  = 64;
    localparam int unsigned N_DEF  = 16;
    localparam int unsigned AW_DEF = 4;
    localparam int unsigned NR_DEF = 2;
    localparam int unsigned NW_DEF = 2;

    // Number of byte lanes in a data word of width w.
    function automatic int unsigned nbytes(input int unsigned w);
        return w / 8;
    endfunction

endpackage

// File: rtl/regfile_mp_wmerge.sv
// Combinational per-register write merge: applies every write port's byte enables in
// ascending port order so the highest port index wins each byte, and flags byte overlaps.
module regfile_mp_wmerge
    import regfile_mp_pkg::*;
#(
    parameter int unsigned W        = W_DEF,
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned NW       = NW_DEF,
    parameter int unsigned IDX      = 0,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic [W-1:0]        old_val,
    input  logic [NW-1:0]       wena,
    input  logic [NW*AW-1:0]    waddr,
    input  logic [NW*W-1:0]     wdata,
    input  logic [NW*W/8-1:0]   wbe,
    output logic [W-1:0]        next_val,
    output logic                hit,
    output logic                coll
);

    localparam int unsigned NB = nbytes(W);
    localparam bit LOCKED = ZERO_REG && (IDX == 0);

    always_comb begin
        logic [NB-1:0] taken;
        next_val = old_val;
        hit      = 1'b0;
        coll     = 1'b0;
        taken    = '0;
        for (int k = 0; k < int'(NW); k++) begin
            if (!LOCKED && wena[k] && (waddr[k*AW +: AW] == AW'(IDX))) begin
                hit = 1'b1;
                for (int j = 0; j < int'(NB); j++) begin
                    if (wbe[k*NB + j]) begin
                        if (taken[j]) coll = 1'b1;
                        taken[j]             = 1'b1;
                        next_val[j*8 +: 8]   = wdata[k*W + j*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port operand register file with byte enables, port priority, optional bypass,
// optional hardwired-zero register 0, and collision / address-range error pulses.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned W        = W_DEF,
    parameter int unsigned N        = N_DEF,
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned NR       = NR_DEF,
    parameter int unsigned NW       = NW_DEF,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NW-1:0]       wena,
    input  logic [NW*AW-1:0]    waddr,
    input  logic [NW*W-1:0]     wdata,
    input  logic [NW*W/8-1:0]   wbe,
    input  logic [NR-1:0]       rena,
    input  logic [NR*AW-1:0]    raddr,
    output logic [NR*W-1:0]     rdata,
    output logic [NR-1:0]       rvalid,
    output logic                wcoll,
    output logic                aerr
);

    logic [W-1:0]    regs [N];
    logic [W-1:0]    nxt  [N];
    logic [N-1:0]    hit;
    logic [N-1:0]    coll;
    logic [NR*W-1:0] rd_c;
    logic            aerr_c;

    for (genvar gi = 0; gi < int'(N); gi++) begin : g_reg
        regfile_mp_wmerge #(
            .W        (W),
            .AW       (AW),
            .NW       (NW),
            .IDX      (gi),
            .ZERO_REG (ZERO_REG)
        ) u_wmerge (
            .old_val  (regs[gi]),
            .wena     (wena),
            .waddr    (waddr),
            .wdata    (wdata),
            .wbe      (wbe),
            .next_val (nxt[gi]),
            .hit      (hit[gi]),
            .coll     (coll[gi])
        );
    end

    // Any enabled port, read or write, pointing past the last register.
    always_comb begin
        aerr_c = 1'b0;
        for (int k = 0; k < int'(NW); k++) begin
            if (wena[k] && (32'(waddr[k*AW +: AW]) >= N)) aerr_c = 1'b1;
        end
        for (int r = 0; r < int'(NR); r++) begin
            if (rena[r] && (32'(raddr[r*AW +: AW]) >= N)) aerr_c = 1'b1;
        end
    end

    // Bypass reads take the merged post-write value; out-of-range reads return zero.
    always_comb begin
        rd_c = '0;
        for (int r = 0; r < int'(NR); r++) begin
            if (32'(raddr[r*AW +: AW]) < N) begin
                rd_c[r*W +: W] = BYPASS ? nxt[raddr[r*AW +: AW]] : regs[raddr[r*AW +: AW]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N); i++) regs[i] <= '0;
            rdata  <= '0;
            rvalid <= '0;
            wcoll  <= 1'b0;
            aerr   <= 1'b0;
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                if (hit[i]) regs[i] <= nxt[i];
            end
            for (int r = 0; r < int'(NR); r++) begin
                if (rena[r]) rdata[r*W +: W] <= rd_c[r*W +: W];
            end
            rvalid <= rena;
            wcoll  <= |coll;
            aerr   <= aerr_c;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: instance A uses the defaults (bypass on, 16 registers); instance B has
// bypass off, 12 registers and a hardwired-zero register 0. Both see identical stimulus.
module tb_regfile_mp;

    typedef struct packed {
        logic [1:0]  v;
        logic [63:0] d0;
        logic [63:0] d1;
        logic        wc;
        logic        ae;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [1:0]   wena;
    logic [7:0]   waddr;
    logic [127:0] wdata;
    logic [15:0]  wbe;
    logic [1:0]   rena;
    logic [7:0]   raddr;

    logic [127:0] rdata_a, rdata_b;
    logic [1:0]   rvalid_a, rvalid_b;
    logic         wcoll_a, wcoll_b, aerr_a, aerr_b;

    exp_t qa[$];
    exp_t qb[$];
    int   tests_run;
    int   tests_failed;

    regfile_mp u_dut_a (
        .clk(clk), .rst(rst), .wena(wena), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .rena(rena), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a),
        .wcoll(wcoll_a), .aerr(aerr_a)
    );

    regfile_mp #(.N(12), .BYPASS(1'b0), .ZERO_REG(1'b1)) u_dut_b (
        .clk(clk), .rst(rst), .wena(wena), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .rena(rena), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b),
        .wcoll(wcoll_b), .aerr(aerr_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t mk(input logic [1:0] v, input logic [63:0] d0,
                                input logic [63:0] d1, input logic wc, input logic ae);
        exp_t e;
        e.v = v; e.d0 = d0; e.d1 = d1; e.wc = wc; e.ae = ae;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic check_dut(input string id, input exp_t e, input logic [1:0] rv,
                             input logic [127:0] rd, input logic wc, input logic ae);
        chk({id, ".rvalid"}, 64'(rv), 64'(e.v));
        chk({id, ".wcoll"},  64'(wc), 64'(e.wc));
        chk({id, ".aerr"},   64'(ae), 64'(e.ae));
        if (e.v[0]) chk({id, ".rdata0"}, rd[63:0],   e.d0);
        if (e.v[1]) chk({id, ".rdata1"}, rd[127:64], e.d1);
    endtask

    // Monitor: one expectation per DUT per clock, checked mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                check_dut("A", e, rvalid_a, rdata_a, wcoll_a, aerr_a);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                check_dut("B", e, rvalid_b, rdata_b, wcoll_b, aerr_b);
            end
        end
    end

    task automatic idle_inputs();
        rst = 1'b0; wena = '0; waddr = '0; wdata = '0; wbe = '0; rena = '0; raddr = '0;
    endtask

    task automatic set_w(input int k, input logic [3:0] a, input logic [63:0] d,
                         input logic [7:0] be);
        wena[k]         = 1'b1;
        waddr[k*4 +: 4] = a;
        wdata[k*64 +: 64] = d;
        wbe[k*8 +: 8]   = be;
    endtask

    task automatic set_r(input int r, input logic [3:0] a);
        rena[r]         = 1'b1;
        raddr[r*4 +: 4] = a;
    endtask

    // Apply the current inputs for one edge and queue what each DUT should show after it.
    task automatic cycle(input exp_t ea, input exp_t eb);
        @(posedge clk);
        qa.push_back(ea);
        qb.push_back(eb);
        #1;
        idle_inputs();
    endtask

    localparam logic [63:0] Z    = 64'h0;
    localparam logic [63:0] R3   = 64'h11223344AAAAAAAA;
    localparam logic [63:0] R7   = 64'hFFFFFFFF00000000;
    localparam logic [63:0] R9   = 64'h1111111122222222;

    initial begin
        exp_t i0;
        tests_run    = 0;
        tests_failed = 0;
        i0 = mk(2'b00, Z, Z, 1'b0, 1'b0);
        idle_inputs();

        // Reset then read
        rst = 1'b1; cycle(i0, i0);
        rst = 1'b1; cycle(i0, i0);
        set_r(0, 4'd5); set_r(1, 4'd15);
        cycle(mk(2'b11, Z, Z, 1'b0, 1'b0), mk(2'b11, Z, Z, 1'b0, 1'b1));

        // Byte merge across two cycles
        set_w(0, 4'd3, 64'h1122334455667788, 8'hFF);
        cycle(i0, i0);
        set_w(1, 4'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        cycle(i0, i0);
        set_r(0, 4'd3);
        cycle(mk(2'b01, R3, Z, 1'b0, 1'b0), mk(2'b01, R3, Z, 1'b0, 1'b0));

        // Same-cycle collision, higher port wins the overlapping bytes
        set_w(0, 4'd7, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        set_w(1, 4'd7, 64'h0, 8'h0F);
        cycle(mk(2'b00, Z, Z, 1'b1, 1'b0), mk(2'b00, Z, Z, 1'b1, 1'b0));
        set_r(1, 4'd7);
        cycle(mk(2'b10, Z, R7, 1'b0, 1'b0), mk(2'b10, Z, R7, 1'b0, 1'b0));

        // Bypass versus read-first
        set_w(0, 4'd9, 64'hDEAD, 8'hFF); set_r(0, 4'd9);
        cycle(mk(2'b01, 64'hDEAD, Z, 1'b0, 1'b0), mk(2'b01, Z, Z, 1'b0, 1'b0));
        set_w(0, 4'd9, 64'h1111111111111111, 8'hFF);
        set_w(1, 4'd9, 64'h2222222222222222, 8'h0F);
        set_r(0, 4'd9); set_r(1, 4'd9);
        cycle(mk(2'b11, R9, R9, 1'b1, 1'b0), mk(2'b11, 64'hDEAD, 64'hDEAD, 1'b1, 1'b0));
        set_r(0, 4'd9);
        cycle(mk(2'b01, R9, Z, 1'b0, 1'b0), mk(2'b01, R9, Z, 1'b0, 1'b0));

        // Register 0 (hardwired in B) and out-of-range address 13 (only in B)
        set_w(0, 4'd0, 64'h55, 8'hFF); set_w(1, 4'd0, 64'h66, 8'h01); set_r(1, 4'd0);
        cycle(mk(2'b10, Z, 64'h66, 1'b1, 1'b0), mk(2'b10, Z, Z, 1'b0, 1'b0));
        set_r(0, 4'd0);
        cycle(mk(2'b01, 64'h66, Z, 1'b0, 1'b0), mk(2'b01, Z, Z, 1'b0, 1'b0));
        set_w(0, 4'd13, 64'h77, 8'hFF); set_r(1, 4'd13);
        cycle(mk(2'b10, Z, 64'h77, 1'b0, 1'b0), mk(2'b10, Z, Z, 1'b0, 1'b1));
        set_r(0, 4'd13);
        cycle(mk(2'b01, 64'h77, Z, 1'b0, 1'b0), mk(2'b01, Z, Z, 1'b0, 1'b1));
        cycle(i0, i0);

        // Continuous reads with a one-cycle reset in the middle
        set_r(0, 4'd3); set_r(1, 4'd7);
        cycle(mk(2'b11, R3, R7, 1'b0, 1'b0), mk(2'b11, R3, R7, 1'b0, 1'b0));
        rst = 1'b1; set_r(0, 4'd3); set_r(1, 4'd7); set_w(0, 4'd5, 64'hBEEF, 8'hFF);
        cycle(i0, i0);
        set_r(0, 4'd3); set_r(1, 4'd7);
        cycle(mk(2'b11, Z, Z, 1'b0, 1'b0), mk(2'b11, Z, Z, 1'b0, 1'b0));
        set_r(0, 4'd9); set_r(1, 4'd13);
        cycle(mk(2'b11, Z, Z, 1'b0, 1'b0), mk(2'b11, Z, Z, 1'b0, 1'b1));
        set_r(0, 4'd5); set_r(1, 4'd12);
        cycle(mk(2'b11, Z, Z, 1'b0, 1'b0), mk(2'b11, Z, Z, 1'b0, 1'b1));

        @(negedge clk);
        #1;
        if (qa.size() != 0 || qb.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0",
                     qa.size(), qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
